fw_sched: RTL

Iteration scheduler for the Floyd-Warshall datapath. It runs on the system `clk`/`reset` and issues the (k, i, j) index triples in order to the processing-element pipeline through a valid/ready handshake. It inserts bubbles between k passes so that pass k+1 never reads results still in flight from pass k. It reports busy/done status and a cycle count for performance runs.

---
 rtl/fw_pkg.sv | 19 +
 rtl/fw_idx_counter.sv | 44 ++++
 rtl/fw_sched.sv | 77 +++++++
 3 files changed

// File: rtl/fw_pkg.sv
// Shared definitions for the Floyd-Warshall iteration scheduler.
package fw_pkg;

    localparam int CYC_W = 32;

    // FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef logic [2:0] fw_state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fw_idx_counter.sv
// Nested-wrap k/i/j index counter; j is innermost, wrap by compare with N-1.
module fw_idx_counter import fw_pkg::*; #(
    parameter int N = 8,
    localparam int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] k,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic             last_j,
    output logic             last_i,
    output logic             last_k
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    assign last_j = (j == LAST);
    assign last_i = (i == LAST);
    assign last_k = (k == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            k <= '0;
            i <= '0;
            j <= '0;
        end else if (advance) begin
            if (!last_j) begin
                j <= j + 1'b1;
            end else begin
                j <= '0;
                if (!last_i) begin
                    i <= i + 1'b1;
                end else begin
                    i <= '0;
                    k <= last_k ? '0 : k + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fw_sched.sv
// Floyd-Warshall (k,i,j) issue scheduler with inter-pass bubbles, drain and cycle counter.
module fw_sched import fw_pkg::*; #(
    parameter int N = 8,
    parameter int PIPE_DEPTH = 4,
    localparam int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] k,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic             pass_first,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] cycles
);

    localparam int GW = (PIPE_DEPTH < 2) ? 1 : $clog2(PIPE_DEPTH);
    localparam logic [GW-1:0] GLAST = GW'(PIPE_DEPTH - 1);

    fw_state_t       state;
    logic [GW-1:0]   gcnt;
    logic            issue, pass_end, final_issue, clr;
    logic            last_j, last_i, last_k;

    assign out_valid   = (state == ST_RUN);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign pass_first  = out_valid && (i == '0) && (j == '0);
    assign issue       = out_valid && out_ready;
    assign pass_end    = issue && last_j && last_i;
    assign final_issue = pass_end && last_k;
    assign clr         = (state == ST_IDLE) && start;

    // The final issue does not advance, so DONE shows the last issued triple.
    fw_idx_counter #(.N(N)) u_idx (
        .clk     (clk),
        .reset   (reset),
        .clear   (clr),
        .advance (issue && !final_issue),
        .k       (k),
        .i       (i),
        .j       (j),
        .last_j  (last_j),
        .last_i  (last_i),
        .last_k  (last_k)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            gcnt   <= '0;
            cycles <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state  <= ST_RUN;
                    cycles <= '0;
                end
                ST_RUN: if (pass_end) begin
                    state <= last_k ? ST_DRAIN : ST_GAP;
                    gcnt  <= '0;
                end
                ST_GAP:   if (gcnt == GLAST) state <= ST_RUN;   else gcnt <= gcnt + 1'b1;
                ST_DRAIN: if (gcnt == GLAST) state <= ST_DONE;  else gcnt <= gcnt + 1'b1;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            if ((state == ST_RUN || state == ST_GAP || state == ST_DRAIN) && (cycles != '1))
                cycles <= cycles + 1'b1;
        end
    end

endmodule
